// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between fetch_sequencer (slave side) and the datapath / program
// counter environment (master side).
interface fetch_sequencer_if #(
  parameter int D  = 12,
  parameter int LW = 4,
  parameter int CW = 16
);
  logic          start;
  logic [D-1:0]  prog_ctr;
  logic          exec_done;
  logic          take_branch;
  logic [LW-1:0] branch_idx;
  logic          halt_req;
  logic          lut_we;
  logic [LW-1:0] lut_addr;
  logic [D-1:0]  lut_data;
  logic          nextFlag;
  logic          absjump_en;
  logic [D-1:0]  target;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] icount;

  modport master (
    output start, prog_ctr, exec_done, take_branch, branch_idx, halt_req,
           lut_we, lut_addr, lut_data,
    input  nextFlag, absjump_en, target, instr_valid, busy, done, err, icount
  );

  modport slave (
    input  start, prog_ctr, exec_done, take_branch, branch_idx, halt_req,
           lut_we, lut_addr, lut_data,
    output nextFlag, absjump_en, target, instr_valid, busy, done, err, icount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Control partner of the program counter: paces instruction retirement around the
// counter's two-stage lag, resolves branches through a writable jump LUT, detects halt.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// WAIT  | counter updated, prog_ctr not yet caught up
// EXEC  | prog_ctr stable, datapath executing
// STEP  | one-cycle advance pulse to the counter
// HALT  | program finished (done, optionally err) until reset
module fetch_sequencer #(
  parameter int D  = 12,
  parameter int LW = 4,
  parameter int CW = 16
) (
  input logic clk,
  input logic reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EXEC, S_STEP, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  lut [2**LW];
  logic          jump_q, jump_d;
  logic [D-1:0]  tgt_q, tgt_d;
  logic          err_q, err_d;
  logic [CW-1:0] icount_q, icount_d;

  logic          next_flag_d, absjump_d, instr_valid_d, busy_d, done_d, err_out_d;
  logic [D-1:0]  target_d;
  logic          next_flag_q, absjump_q, instr_valid_q, busy_q, done_q, err_out_q;
  logic [D-1:0]  target_q;

  logic accept;
  assign accept = (state_q == S_EXEC) && bus.exec_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      jump_q        <= 1'b0;
      tgt_q         <= '0;
      err_q         <= 1'b0;
      icount_q      <= '0;
      next_flag_q   <= 1'b0;
      absjump_q     <= 1'b0;
      target_q      <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_out_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      jump_q        <= jump_d;
      tgt_q         <= tgt_d;
      err_q         <= err_d;
      icount_q      <= icount_d;
      next_flag_q   <= next_flag_d;
      absjump_q     <= absjump_d;
      target_q      <= target_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_out_q     <= err_out_d;
    end
  end

  // The branch read in the next-state logic sees the pre-write entry on a same-cycle hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**LW; i++) lut[i] <= '0;
    end else if (bus.lut_we) begin
      lut[bus.lut_addr] <= bus.lut_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    jump_d   = jump_q;
    tgt_d    = tgt_q;
    err_d    = err_q;
    icount_d = icount_q;
    if (accept && (icount_q != '1)) icount_d = icount_q + 1'b1;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_WAIT;
      S_WAIT: state_d = S_EXEC;
      S_EXEC: begin
        if (bus.exec_done) begin
          if (bus.halt_req) begin
            state_d = S_HALT;
          end else if (bus.take_branch) begin
            jump_d  = 1'b1;
            tgt_d   = lut[bus.branch_idx];
            state_d = S_STEP;
          end else if (bus.prog_ctr == '1) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            jump_d  = 1'b0;
            tgt_d   = '0;
            state_d = S_STEP;
          end
        end
      end
      S_STEP: state_d = S_WAIT;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with the state.
  always_comb begin
    next_flag_d   = (state_d == S_STEP);
    absjump_d     = next_flag_d && jump_d;
    target_d      = next_flag_d ? tgt_d : '0;
    instr_valid_d = (state_d == S_EXEC);
    busy_d        = (state_d == S_WAIT) || (state_d == S_EXEC) || (state_d == S_STEP);
    done_d        = (state_d == S_HALT);
    err_out_d     = (state_d == S_HALT) && err_d;
  end

  assign bus.nextFlag    = next_flag_q;
  assign bus.absjump_en  = absjump_q;
  assign bus.target      = target_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_out_q;
  assign bus.icount      = icount_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control-side partner of the program counter. Issues the one-cycle advance pulse (`nextFlag`), plus `absjump_en` and `target`, for each retired instruction. Absorbs the counter's two-stage register lag so that an instruction is only exposed to the datapath once `prog_ctr` is stable. Branch targets come from an internal writable jump LUT; the block also detects halt and counter fall-off, and counts retired instructions.

## Interface
Parameters:
- `D`, default 12: program counter width.
- `LW`, default 4: jump-LUT index width (2^LW entries of D bits).
- `CW`, default 16: retired-instruction counter width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin execution; sampled in IDLE only.
- `prog_ctr`  in  D  current program counter value.
- `exec_done`  in  1  datapath has finished the current instruction; sampled in EXEC only.
- `take_branch`  in  1  valid with `exec_done`; requests an absolute jump.
- `branch_idx`  in  LW  valid with `exec_done`; selects the jump LUT entry.
- `halt_req`  in  1  valid with `exec_done`; current instruction is a halt.
- `lut_we`  in  1  jump-LUT write enable.
- `lut_addr`  in  LW  jump-LUT write index.
- `lut_data`  in  D  jump-LUT write data.
- `nextFlag`  out  1  one-cycle advance pulse to the program counter.
- `absjump_en`  out  1  qualifies `nextFlag` as an absolute jump.
- `target`  out  D  jump destination.
- `instr_valid`  out  1  `prog_ctr` is stable; the datapath may execute.
- `busy`  out  1  high in WAIT, EXEC and STEP.
- `done`  out  1  sticky; program has halted.
- `err`  out  1  sticky; halt was caused by fall-off past the maximum `prog_ctr`.
- `icount`  out  CW  number of retired instructions, saturating.

## Operation
- States are IDLE, WAIT, EXEC, STEP and HALT. The FSM is Moore-style and all outputs are registered.
- In IDLE, all outputs are 0. `start` moves the FSM to WAIT.
- WAIT lasts one cycle. It covers the cycle in which the counter has updated but `prog_ctr` has not yet caught up. The FSM then moves to EXEC.
- In EXEC, `instr_valid` is 1 and the FSM holds until `exec_done` is 1. On `exec_done`, priority is:
  1. `halt_req`: go to HALT with `done` set.
  2. `take_branch`: latch `target` = LUT[`branch_idx`] and `absjump_en` = 1, then go to STEP.
  3. `prog_ctr` equal to all ones: go to HALT with `done` and `err` set. The block never issues a wrap-around step.
  4. Otherwise: go to STEP with `absjump_en` = 0 and `target` = 0.
- `icount` increments once per `exec_done` accepted in EXEC, halts included. It saturates at all ones.
- In STEP, `nextFlag` is 1 for exactly one cycle, with `absjump_en` and `target` as latched. The FSM then returns to WAIT.
- Outside STEP, `nextFlag`, `absjump_en` and `target` are 0.
- HALT holds `done` (and `err` if set) until `reset`; `start` is ignored.
- `exec_done`, `take_branch`, `branch_idx` and `halt_req` are ignored outside EXEC.
- Jump LUT:
  - All entries reset to 0.
  - A write takes effect at the next edge and is accepted in every state.
  - If a write hits the same index being read on an accepted `exec_done`, the old entry is used.
- Reset mid-operation: the FSM returns to IDLE; all outputs, `icount` and the LUT clear at the same edge. Any pending STEP is dropped and no `nextFlag` is emitted.

## Timing
- Reset values: `nextFlag`=0, `absjump_en`=0, `target`=0, `instr_valid`=0, `busy`=0, `done`=0, `err`=0, `icount`=0, state IDLE.
- `start` high in cycle N gives WAIT in N+1 and EXEC (`instr_valid`=1) in N+2.
- `exec_done` high in EXEC cycle M gives:
  - STEP in M+1 (`nextFlag`=1);
  - WAIT in M+2;
  - EXEC in M+3, with the new `prog_ctr` visible.
- Minimum instruction period is 3 cycles.
- `instr_valid` falls in the cycle after the accepted `exec_done`.
- On the halt path, `done` rises in M+1 and no `nextFlag` is ever issued.
- `icount` updates in M+1.

## Test plan
- Sequential run: reset, `start`, `exec_done` on the first cycle of every EXEC for 5 instructions. Required: 5 `nextFlag` pulses spaced 3 cycles apart, `absjump_en`=0, `prog_ctr` 0→5, `icount`=5.
- Branch via LUT: write LUT[3]=12'h0A0, then at `prog_ctr`=2 drive `exec_done`, `take_branch`=1, `branch_idx`=3. Required: one-cycle `nextFlag` with `absjump_en`=1 and `target`=12'h0A0; `prog_ctr`=12'h0A0 when `instr_valid` next rises.
- Halt priority: `exec_done` with `halt_req`=1 and `take_branch`=1. Required: `done`=1 the next cycle, no `nextFlag`, `err`=0; later `start` pulses and `exec_done` pulses have no effect.
- Fall-off: `prog_ctr`=12'hFFF with `exec_done` and no branch. Required: `done`=1, `err`=1, no `nextFlag`.
- Stall and hazards:
  - Holding `exec_done` low for 10 cycles keeps `instr_valid`=1 with no pulse.
  - `lut_we` to LUT[3] in the same cycle as an accepted branch on index 3 uses the old value.
  - `reset` asserted in a STEP cycle clears all outputs at the next edge, with no `nextFlag` afterward.
